// File: rtl/rr_grant_arbiter.sv
// Round-robin grant engine: one owner per tenure, held until done,
// owner drop or hold limit, then handed over with no idle bubble.
module rr_grant_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16,
  localparam int IW = $clog2(WIDTH),
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             done,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_idx
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // Saturation point of the tenure counter; with no limit it pins at max.
  localparam logic [HW-1:0] LIM =
    (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] grant_d;
  logic [HW-1:0]    hold_cnt;
  logic [HW-1:0]    hold_nxt;

  logic [WIDTH-1:0] others;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] pick;
  logic             owner_req;
  logic             at_limit;
  logic             release_now;

  function automatic logic [WIDTH-1:0] lowest(input logic [WIDTH-1:0] x);
    return x & (~x + WIDTH'(1));
  endfunction

  // Candidate selection: masked requesters first, else wrap to lowest.
  always_comb begin
    others      = req & ~grant;
    cand        = (state_q == BUSY) ? others : req;
    mcand       = cand & mask_in;
    pick        = (mcand != '0) ? lowest(mcand) : lowest(cand);
    owner_req   = |(req & grant);
    at_limit    = (MAX_HOLD != 0) && (hold_cnt >= LIM) && (others != '0);
    release_now = (hold_cnt != '0) && (done || !owner_req || at_limit);
  end

  // Next-state, next-grant and tenure counter.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    hold_nxt = hold_cnt;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          grant_d  = pick;
          state_d  = BUSY;
          hold_nxt = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          hold_nxt = '0;
          if (others != '0) begin
            grant_d = pick;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (hold_cnt != LIM) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        hold_nxt = '0;
      end
    endcase
  end

  // State, grant and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant    <= '0;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      hold_cnt <= hold_nxt;
    end
  end

  // Binary index and valid derived from the grant register.
  always_comb begin
    grant_idx   = '0;
    grant_valid = |grant;
    for (int i = 0; i < WIDTH; i++) begin
      if (grant[i]) grant_idx = IW'(i);
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random traffic
// against an owner/age reference model, with a mask stage emulated here.
module tb_rr_grant_arbiter;

  localparam int W  = 8;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] req = '0;
  logic [W-1:0] mask_in;
  logic         done = 1'b0;
  logic [W-1:0] grant;
  logic         grant_valid;
  logic [2:0]   grant_idx;

  int checks = 0;
  int failures = 0;

  rr_grant_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .mask_in(mask_in),
    .done(done),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  // Mask stage: bits strictly above the granted one, one clock later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_in <= '0;
    else mask_in <= ~(grant | (grant - 1'b1));
  end

  // Reference model: owner index (-1 = none), tenure age, and the
  // owner of the previous cycle, which is what the mask reflects.
  int m_owner = -1;
  int m_age = 0;
  int m_prev = W - 1;

  function automatic int pick(input logic [W-1:0] c, input int after);
    for (int i = after + 1; i < W; i++) if (c[i]) return i;
    for (int i = 0; i < W; i++) if (c[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int cur;
    logic [W-1:0] oth;
    if (!rst_n) begin
      m_owner = -1;
      m_age = 0;
      m_prev = W - 1;
    end else begin
      cur = m_owner;
      if (cur < 0) begin
        if (req != 0) begin
          m_owner = pick(req, m_prev);
          m_age = 0;
        end
      end else begin
        oth = req;
        oth[cur] = 1'b0;
        if (m_age >= 1 &&
            (done || !req[cur] || (m_age >= MH - 1 && oth != 0))) begin
          m_owner = (oth != 0) ? pick(oth, m_prev) : -1;
          m_age = 0;
        end else if (m_age < MH - 1) begin
          m_age++;
        end
      end
      m_prev = (cur < 0) ? W - 1 : cur;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [W-1:0] eg;
    if (rst_n) begin
      eg = (m_owner < 0) ? '0 : W'(1) << m_owner;
      checks++;
      if (grant !== eg || grant_valid !== (m_owner >= 0) ||
          grant_idx !== 3'((m_owner < 0) ? 0 : m_owner)) begin
        failures++;
        $display("FAIL model t=%0t grant=%h/%b/%0d required=%h/%b/%0d",
                 $time, grant, grant_valid, grant_idx,
                 eg, m_owner >= 0, (m_owner < 0) ? 0 : m_owner);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e;
    #12;
    chk("reset_grant", int'(grant), 0);
    chk("reset_valid", int'(grant_valid), 0);
    chk("reset_idx", int'(grant_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Full rotation with done in each tenure's second cycle.
    req = 8'hFF;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      e = 1 << (k % 8);
      chk("rot_c1", int'(grant), e);
      done = 1'b0;
      @(negedge clk);
      chk("rot_c2", int'(grant), e);
      done = 1'b1;
      @(negedge clk);
    end
    done = 1'b0;
    req = '0;
    cyc(4);
    chk("rot_idle", int'(grant), 0);

    // Hold limit alternation between clients 0 and 2.
    req = 8'h05;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      e = (i < 4) ? 1 : (i < 8) ? 4 : 1;
      chk("limit_grant", int'(grant), e);
      chk("limit_idx", int'(grant_idx), (e == 4) ? 2 : 0);
      @(negedge clk);
    end
    req = '0;
    cyc(4);

    // Lone requester held indefinitely, counter saturated.
    req = 8'h10;
    cyc(22);
    chk("solo_grant", int'(grant), 8'h10);
    chk("solo_hold", int'(dut.hold_cnt), MH - 1);
    req = 8'h11;
    @(negedge clk);
    chk("solo_handover", int'(grant), 8'h01);
    req = '0;
    cyc(4);

    // Owner drops to idle, then priority restarts at bit 0.
    req = 8'h04;
    cyc(2);
    chk("drop_own", int'(grant), 8'h04);
    req = '0;
    @(negedge clk);
    chk("drop_grant", int'(grant), 0);
    chk("drop_valid", int'(grant_valid), 0);
    @(negedge clk);
    req = 8'h82;
    @(negedge clk);
    chk("restart", int'(grant), 8'h02);
    req = '0;
    cyc(4);

    // done in first BUSY cycle ignored; done in third cycle honoured.
    req = 8'h06;
    @(negedge clk);
    chk("early_c1", int'(grant), 8'h02);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("early_c2", int'(grant), 8'h02);
    @(negedge clk);
    chk("early_c3", int'(grant), 8'h02);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("late_done", int'(grant), 8'h04);
    req = '0;
    cyc(4);

    // Asynchronous reset mid-tenure.
    req = 8'h08;
    cyc(3);
    chk("pre_rst", int'(grant), 8'h08);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", int'(grant), 0);
    chk("async_valid", int'(grant_valid), 0);
    chk("async_idx", int'(grant_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst", int'(grant), 8'h08);
    req = '0;
    cyc(3);

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 7) == 0) req = '0;
        else req = W'($urandom) & W'($urandom | $urandom);
      end
      done = ($urandom_range(0, 4) == 0);
      @(negedge clk);
    end
    req = '0;
    done = 1'b0;
    cyc(4);
    chk("final_idle", int'(grant), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
